opendap_mem_ap: RTL and testbench
=================================

# opendap_mem_ap

Memory Access Port that answers the SW-DP's AP interface: decodes AP register reads/writes, holds CSW/TAR, and turns DRW/BDn accesses into single transfers on a simple req/ack downstream bus. Sits directly behind the SW-DP in the `swclk` domain. Any clock-domain crossing to the system bus is a separate bridge. It is the responder for every `ap_wen`/`ap_ren` the DP issues, and drives the `ap_rdy`/`ap_err`/`ap_rdata` return path.

## Interface
- `APSEL`, 8'd0: AP number this block answers to.
- `IDR`, 32'h0477_0011: value returned by IDR (0xFC).
- `BASE`, 32'h0000_0003: value returned by BASE (0xF8).
- `swclk` in 1: clock. All logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ap_sel` in 8: AP select. Valid only with `ap_wen`/`ap_ren`.
- `ap_addr` in 6: `{banksel[3:0], A[3:2]}`.
- `ap_wdata` in 32: write data.
- `ap_wen`, `ap_ren` in 1: single-cycle access strobes.
- `ap_abort` in 1: DAPABORT.
- `ap_rdata` out 32: read data.
- `ap_rdy` out 1: AP ready.
- `ap_err` out 1: access error, one-cycle pulse.
- `bus_req` out 1: transfer request. Held until `bus_ack` or abort.
- `bus_addr` out 32: transfer address.
- `bus_write` out 1: 1 = write.
- `bus_size` out 2: 0 = byte, 1 = halfword, 2 = word.
- `bus_wdata` out 32: write data, passed through unshifted (byte-lane data is the host's responsibility).
- `bus_ack` in 1: transfer complete.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `bus_err` in 1: transfer error, valid with `bus_ack`.

## Operation
- **Select match.** An access is claimed only if `ap_sel == APSEL`.
  - Unclaimed reads return 0 with `ap_rdy` kept high and no error.
  - Unclaimed writes are ignored.
- **Register map (`ap_addr`).**
  - 0x00 CSW.
  - 0x01 TAR.
  - 0x03 DRW.
  - 0x04–0x07 BD0–BD3.
  - 0x3D CFG: RO 0.
  - 0x3E BASE.
  - 0x3F IDR.
  - All other addresses read 0, writes ignored. Writes to RO registers are ignored.
- **CSW fields.**
  - [2:0] Size, reset 3'b010. A write of 3..7 leaves Size unchanged.
  - [5:4] AddrInc, reset 0. Bit 5 is RAZ/WI; only values 00 and 01 exist.
  - [6] DeviceEn: RO 1.
  - [7] TrInProg: RO, equals FSM != IDLE.
  - All other bits RAZ/WI.
- **TAR.** 32-bit R/W, reset 0.
- **FSM states.**
  - IDLE: `ap_rdy` = 1.
  - BUS: `bus_req` = 1, `ap_rdy` = 0.
- **Register access (CSW/TAR/IDR/BASE/CFG/RES).**
  - Completes in IDLE.
  - `ap_rdata` is loaded on the strobe edge.
  - `ap_rdy` stays 1; `ap_err` stays 0.
- **DRW access.**
  - On the strobe edge, load `bus_addr` = TAR, `bus_size` = CSW.Size[1:0], `bus_write` = `ap_wen`, `bus_wdata` = `ap_wdata`.
  - Then go IDLE→BUS.
- **BDn access (n = `ap_addr`[1:0]).** Same as DRW, with `bus_addr` = {TAR[31:4], n, 2'b00}.
- **In BUS, on `bus_ack`.**
  - Go →IDLE.
  - On a read, `ap_rdata` ← `bus_rdata`.
  - `ap_err` ← `bus_err` for exactly that one cycle, i.e. the first cycle `ap_rdy` = 1.
- **Auto-increment.**
  - Applies on DRW completion with `bus_err` = 0 and AddrInc = 01.
  - TAR[9:0] ← TAR[9:0] + (1 << Size); TAR[31:10] is unchanged (wraps within the 1 KB block).
  - BDn accesses never increment TAR.
  - An errored DRW leaves TAR unchanged.
- **Strobe while BUS.** `ap_wen`/`ap_ren` while not ready is a DP protocol violation. It is ignored, and no state changes.
- **Abort.**
  - `ap_abort` in any state forces IDLE on the next edge: `ap_rdy` = 1, `ap_err` = 0, `bus_req` = 0.
  - The pending `bus_ack` is then ignored. Downstream must accept a dropped request as a cancellation.
  - TAR and `ap_rdata` are unchanged.
  - Abort takes priority over a simultaneous `bus_ack`: no increment, no `ap_err`.

## Timing
- **Reset values.**
  - `ap_rdy` = 1, `ap_err` = 0, `ap_rdata` = 0.
  - `bus_req` = 0, `bus_addr` = 0, `bus_write` = 0, `bus_size` = 2, `bus_wdata` = 0.
  - FSM = IDLE, CSW = 0x0000_0042 (read value), TAR = 0.
  - Reset mid-transfer drops `bus_req` immediately (asynchronous).
- **Register reads.** `ap_rdata` is valid the cycle after `ap_ren` and held until the next strobe.
- **Bus access latency.**
  - Strobe at edge N → `bus_req` = 1 and `ap_rdy` = 0 from cycle N+1.
  - `bus_ack` sampled at edge M → `bus_req` = 0, `ap_rdy` = 1, data/err valid from cycle M+1.
  - Minimum 2 cycles of `ap_rdy` low is not required: a 0-wait `bus_ack` on the first BUS cycle gives exactly 1 cycle low.
- **Outputs.** All outputs are registered; no combinational path from `bus_*` inputs to `ap_*` outputs.

## Test plan
- **Reset / ID reads.** Reset, read 0x3F, 0x00, 0x3E → `IDR`, 0x0000_0042, `BASE`; `ap_rdy` never low.
- **DRW write with increment.**
  - Stimulus: CSW = 0x12, TAR = 0x2000_03FC, write DRW 0xCAFEF00D three times, `bus_ack` after 3 cycles each.
  - Expect `bus_addr` 0x2000_03FC, 0x2000_0000, 0x2000_0004 (1 KB wrap), `bus_write` = 1, `bus_size` = 2.
  - Expect `ap_rdy` low 3 cycles per access.
- **Byte read, no increment.**
  - Stimulus: CSW = 0x00 (byte), TAR = 0x100, read DRW with `bus_rdata` = 0x11223344.
  - Expect `bus_size` = 0, `ap_rdata` = 0x11223344, TAR still 0x100.
- **BD and error.**
  - Stimulus: TAR = 0x4000_1238, read BD2 with `bus_err` = 1.
  - Expect `bus_addr` = 0x4000_1238, `ap_err` high exactly 1 cycle coincident with `ap_rdy` rising.
  - Repeat as a DRW with AddrInc = 01 → TAR unchanged.
- **Abort.**
  - Stimulus: start DRW read, hold `bus_ack` low 20 cycles, assert `ap_abort` at cycle 5.
  - Expect `bus_req` = 0 and `ap_rdy` = 1 next cycle, `ap_err` = 0, TrInProg reads 0.
  - A late `bus_ack` has no effect.
- **Select mismatch / illegal writes.**
  - Stimulus: `ap_sel` = 1 write TAR and read DRW; then write CSW Size = 5.
  - Expect no `bus_req`, read returns 0, TAR unchanged, CSW Size still 2.

Source files
------------

// File: rtl/opendap_mem_ap.sv
// opendap_mem_ap
//   Memory Access Port behind the SW-DP (swclk domain). Decodes AP register
//   accesses, holds CSW/TAR and turns DRW/BDn accesses into single transfers
//   on a simple req/ack downstream bus.
//
// Ports
//   swclk, rst_n         clock (rising edge), asynchronous active-low reset
//   ap_sel/ap_addr       AP select and {banksel, A[3:2]} register address
//   ap_wdata             write data from the DP
//   ap_wen/ap_ren        single-cycle access strobes
//   ap_abort             DAPABORT: cancels any transfer in flight
//   ap_rdata/ap_rdy/ap_err  return path to the DP (all registered)
//   bus_req..bus_wdata   downstream request, held until bus_ack or abort
//   bus_ack/bus_rdata/bus_err  downstream completion
module opendap_mem_ap #(
  parameter logic [7:0]  APSEL = 8'd0,
  parameter logic [31:0] IDR   = 32'h0477_0011,
  parameter logic [31:0] BASE  = 32'h0000_0003
) (
  input  logic        swclk,
  input  logic        rst_n,
  input  logic [7:0]  ap_sel,
  input  logic [5:0]  ap_addr,
  input  logic [31:0] ap_wdata,
  input  logic        ap_wen,
  input  logic        ap_ren,
  input  logic        ap_abort,
  output logic [31:0] ap_rdata,
  output logic        ap_rdy,
  output logic        ap_err,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [2:0]  csw_size;
  logic        csw_addrinc;
  logic [31:0] tar;
  logic        drw_xfer;      // current transfer came from DRW (may increment TAR)

  logic        claim;
  logic        strobe;
  logic        is_bus_reg;
  logic        start_bus;
  logic        finish_bus;
  logic        reg_access;
  logic [31:0] csw_rd;
  logic [31:0] rd_val;
  logic [9:0]  tar_step;

  assign claim      = (ap_sel == APSEL);
  assign strobe     = ap_wen | ap_ren;
  assign is_bus_reg = (ap_addr == 6'h03) || (ap_addr[5:2] == 4'h1);

  // Both are decoded straight from the state flop, so they are glitch-free
  // registered outputs with no path from the bus_* inputs.
  assign ap_rdy  = (state == IDLE);
  assign bus_req = (state == BUS);

  assign csw_rd   = {24'd0, (state == BUS), 1'b1, 1'b0, csw_addrinc, 1'b0, csw_size};
  assign tar_step = 10'd1 << csw_size;

  // State register
  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and access classification. Abort wins over a strobe in IDLE
  // and over a simultaneous bus_ack in BUS.
  always_comb begin
    state_next = state;
    start_bus  = 1'b0;
    finish_bus = 1'b0;
    reg_access = 1'b0;
    case (state)
      IDLE: begin
        if (!ap_abort && strobe) begin
          if (claim && is_bus_reg) begin
            start_bus  = 1'b1;
            state_next = BUS;
          end else begin
            reg_access = 1'b1;
          end
        end
      end
      BUS: begin
        if (ap_abort) begin
          state_next = IDLE;
        end else if (bus_ack) begin
          finish_bus = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Register read mux; unclaimed reads return zero.
  always_comb begin
    rd_val = 32'd0;
    if (claim) begin
      case (ap_addr)
        6'h00:   rd_val = csw_rd;
        6'h01:   rd_val = tar;
        6'h3E:   rd_val = BASE;
        6'h3F:   rd_val = IDR;
        default: rd_val = 32'd0;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      ap_rdata    <= 32'd0;
      ap_err      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_write   <= 1'b0;
      bus_size    <= 2'd2;
      bus_wdata   <= 32'd0;
      csw_size    <= 3'd2;
      csw_addrinc <= 1'b0;
      tar         <= 32'd0;
      drw_xfer    <= 1'b0;
    end else begin
      // ap_err is a pulse: only the completion cycle can raise it.
      ap_err <= 1'b0;

      if (reg_access) begin
        if (ap_ren) begin
          ap_rdata <= rd_val;
        end else if (claim && ap_wen) begin
          case (ap_addr)
            6'h00: begin
              // Size codes above word do not exist; keep the old size.
              if (ap_wdata[2:0] <= 3'd2) begin
                csw_size <= ap_wdata[2:0];
              end
              csw_addrinc <= ap_wdata[4];
            end
            6'h01:   tar <= ap_wdata;
            default: ;
          endcase
        end
      end

      if (start_bus) begin
        bus_addr  <= (ap_addr == 6'h03) ? tar : {tar[31:4], ap_addr[1:0], 2'b00};
        bus_size  <= csw_size[1:0];
        bus_write <= ap_wen;
        bus_wdata <= ap_wdata;
        drw_xfer  <= (ap_addr == 6'h03);
      end

      if (finish_bus) begin
        if (!bus_write) begin
          ap_rdata <= bus_rdata;
        end
        ap_err <= bus_err;
        // Increment wraps inside the 1 KB block; upper TAR bits are kept.
        if (drw_xfer && !bus_err && csw_addrinc) begin
          tar[9:0] <= tar[9:0] + tar_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_opendap_mem_ap.sv
// Randomised scoreboard bench for opendap_mem_ap. The driver computes the
// expected AP response and bus request from a register-level model and
// queues them; a monitor compares whenever the DUT presents a request or
// completes an access; a responder plays the downstream bus.
module tb_opendap_mem_ap;

  localparam logic [31:0] IDR_V  = 32'h0477_0011;
  localparam logic [31:0] BASE_V = 32'h0000_0003;

  logic        swclk = 1'b0;
  logic        rst_n;
  logic [7:0]  ap_sel;
  logic [5:0]  ap_addr;
  logic [31:0] ap_wdata;
  logic        ap_wen;
  logic        ap_ren;
  logic        ap_abort;
  logic [31:0] ap_rdata;
  logic        ap_rdy;
  logic        ap_err;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  always #5 swclk = ~swclk;

  opendap_mem_ap #(.APSEL(8'd0), .IDR(IDR_V), .BASE(BASE_V)) dut (
    .swclk(swclk), .rst_n(rst_n),
    .ap_sel(ap_sel), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
    .ap_wen(ap_wen), .ap_ren(ap_ren), .ap_abort(ap_abort),
    .ap_rdata(ap_rdata), .ap_rdy(ap_rdy), .ap_err(ap_err),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_size(bus_size), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          err;
    int          low;
  } ap_exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  ap_exp_t  ap_q[$];
  bus_exp_t bus_q[$];
  rsp_t     rsp_q[$];

  // Register-level reference model
  logic [2:0]  m_size  = 3'd2;
  bit          m_inc   = 1'b0;
  logic [31:0] m_tar   = 32'd0;
  logic [31:0] m_rdata = 32'd0;

  // Monitor
  bit mon_en   = 1'b1;
  bit pending  = 1'b0;
  bit prev_req = 1'b0;
  int lowcnt   = 0;

  always @(negedge swclk) begin
    if (mon_en && rst_n) begin
      if (pending && ap_rdy) begin
        ap_exp_t e;
        pending = 1'b0;
        if (ap_q.size() == 0) begin
          chk("ap_q_nonempty", 32'(ap_q.size()), 32'd1);
        end else begin
          e = ap_q.pop_front();
          $display("AP  access done rd=%0d rdata=%08h err=%0d low=%0d", e.rd, ap_rdata, ap_err, lowcnt);
          if (e.rd) chk("ap_rdata", ap_rdata, e.rdata);
          chk("ap_err", 32'(ap_err), 32'(e.err));
          chk("ap_rdy_low_cycles", 32'(lowcnt), 32'(e.low));
        end
      end else begin
        chk("ap_err_quiet", 32'(ap_err), 32'd0);
        if (pending) lowcnt++;
      end
      if (ap_rdy && (ap_wen || ap_ren)) begin
        pending = 1'b1;
        lowcnt  = 0;
      end
      if (bus_req && !prev_req) begin
        bus_exp_t b;
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_req", 32'(bus_req), 32'd0);
        end else begin
          b = bus_q.pop_front();
          $display("BUS request addr=%08h wr=%0d size=%0d wdata=%08h", bus_addr, bus_write, bus_size, bus_wdata);
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_write", 32'(bus_write), 32'(b.wr));
          chk("bus_size", 32'(bus_size), 32'(b.size));
          chk("bus_wdata", bus_wdata, b.wdata);
        end
      end
    end
    prev_req = bus_req;
  end

  // Downstream responder: acks on BUS cycle 'delay' (1 = zero-wait). A
  // dropped request does not stop it, which exercises late acks after abort.
  initial begin
    rsp_t r;
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(negedge swclk);
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = $urandom;
      if (bus_req && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        for (int j = 1; j < r.delay; j++) @(negedge swclk);
        bus_ack   = 1'b1;
        bus_rdata = r.rdata;
        bus_err   = r.err;
      end
    end
  end

  // One AP access: update model, queue expectations, drive the strobe and
  // wait (bounded) for ap_rdy. abort_at = BUS cycle in which to abort (0 = none).
  task automatic access(input bit wr, input logic [7:0] sel, input logic [5:0] addr,
                        input logic [31:0] wdata, input int delay, input logic [31:0] brd,
                        input bit berr, input int abort_at, input bit stray);
    ap_exp_t     e;
    bus_exp_t    b;
    rsp_t        r;
    bit          claim;
    bit          busacc;
    bit          aborted;
    logic [31:0] v;
    int          j;
    claim   = (sel == 8'd0);
    busacc  = claim && (addr == 6'h03 || addr[5:2] == 4'h1);
    aborted = busacc && abort_at > 0 && abort_at <= delay;
    e.rd  = !wr;
    e.err = 1'b0;
    e.low = 0;
    if (!claim) begin
      if (!wr) m_rdata = 32'd0;
    end else if (busacc) begin
      b.addr  = (addr == 6'h03) ? m_tar : {m_tar[31:4], addr[1:0], 2'b00};
      b.wr    = wr;
      b.size  = m_size[1:0];
      b.wdata = wdata;
      bus_q.push_back(b);
      r.delay = delay;
      r.rdata = brd;
      r.err   = berr;
      rsp_q.push_back(r);
      if (aborted) begin
        e.low = abort_at;
      end else begin
        e.low = delay;
        e.err = berr;
        if (!wr) m_rdata = brd;
        if (addr == 6'h03 && !berr && m_inc)
          m_tar = {m_tar[31:10], m_tar[9:0] + (10'd1 << m_size)};
      end
    end else if (wr) begin
      if (addr == 6'h00) begin
        if (wdata[2:0] <= 3'd2) m_size = wdata[2:0];
        m_inc = wdata[4];
      end else if (addr == 6'h01) begin
        m_tar = wdata;
      end
    end else begin
      case (addr)
        6'h00:   v = 32'h40 | (32'(m_inc) << 4) | 32'(m_size);
        6'h01:   v = m_tar;
        6'h3E:   v = BASE_V;
        6'h3F:   v = IDR_V;
        default: v = 32'd0;
      endcase
      m_rdata = v;
    end
    e.rdata = m_rdata;
    ap_q.push_back(e);

    ap_sel   = sel;
    ap_addr  = addr;
    ap_wdata = wdata;
    ap_wen   = wr;
    ap_ren   = !wr;
    @(posedge swclk); #1;
    ap_wen = 1'b0;
    ap_ren = 1'b0;
    j = 1;
    while (!ap_rdy && j < 200) begin
      if (stray && j == 1) begin
        ap_sel   = 8'd0;
        ap_addr  = 6'h01;
        ap_wdata = $urandom;
        ap_wen   = 1'b1;
      end
      if (abort_at == j) ap_abort = 1'b1;
      @(posedge swclk); #1;
      ap_wen   = 1'b0;
      ap_abort = 1'b0;
      j++;
    end
    chk("ap_rdy_return", 32'(ap_rdy), 32'd1);
    if (aborted) repeat (delay + 2) @(posedge swclk);
    #1;
  endtask

  task automatic rd(input logic [5:0] addr);
    access(1'b0, 8'd0, addr, 32'd0, 1, 32'd0, 1'b0, 0, 1'b0);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data);
    access(1'b1, 8'd0, addr, data, 1, 32'd0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ap_sel   = 8'd0;
    ap_addr  = 6'd0;
    ap_wdata = 32'd0;
    ap_wen   = 1'b0;
    ap_ren   = 1'b0;
    ap_abort = 1'b0;
    repeat (3) @(posedge swclk);
    #1;
    chk("rst_ap_rdy", 32'(ap_rdy), 32'd1);
    chk("rst_ap_err", 32'(ap_err), 32'd0);
    chk("rst_ap_rdata", ap_rdata, 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_write", 32'(bus_write), 32'd0);
    chk("rst_bus_size", 32'(bus_size), 32'd2);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge swclk); #1;

    // ID / reset-value reads
    rd(6'h3F);
    rd(6'h00);
    rd(6'h3E);
    rd(6'h3D);

    // DRW write with increment across the 1 KB boundary
    wr(6'h00, 32'h12);
    wr(6'h01, 32'h2000_03FC);
    repeat (3) access(1'b1, 8'd0, 6'h03, 32'hCAFE_F00D, 3, 32'd0, 1'b0, 0, 1'b0);
    rd(6'h01);
    chk("tar_after_wrap", m_tar, 32'h2000_0008);

    // Byte read, no increment
    wr(6'h00, 32'h00);
    wr(6'h01, 32'h100);
    access(1'b0, 8'd0, 6'h03, 32'd0, 2, 32'h1122_3344, 1'b0, 0, 1'b0);
    rd(6'h01);

    // BD2 read with error, then errored DRW with increment enabled
    wr(6'h01, 32'h4000_1238);
    access(1'b0, 8'd0, 6'h06, 32'd0, 2, 32'h5555_AAAA, 1'b1, 0, 1'b0);
    wr(6'h00, 32'h12);
    access(1'b0, 8'd0, 6'h03, 32'd0, 2, 32'h6666_7777, 1'b1, 0, 1'b0);
    rd(6'h01);

    // Zero-wait ack
    access(1'b0, 8'd0, 6'h03, 32'd0, 1, 32'h0BAD_CAFE, 1'b0, 0, 1'b0);

    // Abort with a late ack; then abort coinciding with ack
    access(1'b0, 8'd0, 6'h03, 32'd0, 20, 32'hDEAD_BEEF, 1'b0, 5, 1'b0);
    rd(6'h00);
    rd(6'h01);
    access(1'b0, 8'd0, 6'h03, 32'd0, 3, 32'h1357_9BDF, 1'b1, 3, 1'b0);
    rd(6'h01);

    // Select mismatch and illegal size write
    access(1'b1, 8'd1, 6'h01, 32'hDEAD_0000, 1, 32'd0, 1'b0, 0, 1'b0);
    access(1'b0, 8'd1, 6'h03, 32'd0, 1, 32'd0, 1'b0, 0, 1'b0);
    wr(6'h00, 32'h05);
    rd(6'h00);
    rd(6'h01);

    // Strobe during BUS is ignored
    access(1'b1, 8'd0, 6'h04, 32'hA5A5_5A5A, 4, 32'd0, 1'b0, 0, 1'b1);
    rd(6'h01);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      logic [5:0]  a;
      logic [7:0]  s;
      int          d;
      int          ab;
      case ($urandom_range(0, 9))
        0:       a = 6'h00;
        1, 9:    a = 6'h01;
        2, 4:    a = 6'h03;
        3:       a = 6'h04 + 6'($urandom_range(0, 3));
        5:       a = 6'h3D;
        6:       a = 6'h3E;
        7:       a = 6'h3F;
        default: a = 6'($urandom);
      endcase
      s  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      d  = $urandom_range(1, 5);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, d) : 0;
      access(1'($urandom), s, a, $urandom, d, $urandom, ($urandom_range(0, 3) == 0),
             ab, ($urandom_range(0, 7) == 0));
    end
    rd(6'h01);
    rd(6'h00);
    repeat (2) @(posedge swclk);
    #1;
    chk("ap_q_drained", 32'(ap_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);

    // Asynchronous reset during a transfer drops bus_req immediately
    mon_en = 1'b0;
    begin
      rsp_t r;
      r.delay = 50;
      r.rdata = 32'd0;
      r.err   = 1'b0;
      rsp_q.push_back(r);
    end
    ap_sel  = 8'd0;
    ap_addr = 6'h03;
    ap_ren  = 1'b1;
    @(posedge swclk); #1;
    ap_ren = 1'b0;
    @(posedge swclk); #2;
    chk("bus_req_before_rst", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bus_req", 32'(bus_req), 32'd0);
    chk("async_rst_ap_rdy", 32'(ap_rdy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
